// File: rtl/hamming_pkg.sv
// Shared Hamming(12,8) definitions: widths, data-bit placement and the
// syndrome/extract helpers used by both the encoder and the decoder.
package hamming_pkg;

    localparam int CODE_W = 12;
    localparam int DATA_W = 8;
    localparam int SYN_W  = 4;

    // Code index of data bit i (parity bits sit at indices 0,1,3,7).
    localparam int DATA_IDX [DATA_W] = '{2, 4, 5, 6, 8, 9, 10, 11};

    function automatic logic [SYN_W-1:0] hamming_syndrome(input logic [CODE_W-1:0] code);
        return {^(code & 12'hF80), ^(code & 12'h878), ^(code & 12'h666), ^(code & 12'h555)};
    endfunction

    function automatic logic [DATA_W-1:0] hamming_extract(input logic [CODE_W-1:0] code);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W; i++) begin
            d[i] = code[DATA_IDX[i]];
        end
        return d;
    endfunction

endpackage

// File: rtl/hamming_12_8_syndrome.sv
// Combinational syndrome generator feeding decoder stage 1.
module hamming_12_8_syndrome
    import hamming_pkg::*;
(
    input  logic [CODE_W-1:0] i_code,
    output logic [SYN_W-1:0]  o_syndrome
);

    assign o_syndrome = hamming_syndrome(i_code);

endmodule

// File: rtl/hamming_12_8_dec.sv
// Two-stage streaming Hamming(12,8) SEC decoder with valid/ready backpressure
// and saturating corrected/uncorrectable word counters.
module hamming_12_8_dec
    import hamming_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SYN_W-1:0]  out_syndrome,
    output logic              out_corrected,
    output logic              out_uncorrectable,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    logic              r_s1_valid;
    logic [CODE_W-1:0] r_s1_code;
    logic [SYN_W-1:0]  r_s1_syn;
    logic              r_s2_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [SYN_W-1:0]  r_out_syn;
    logic              r_out_corr;
    logic              r_out_uncorr;
    logic [CNT_W-1:0]  r_corr_cnt;
    logic [CNT_W-1:0]  r_uncorr_cnt;

    logic              w_s1_ready;
    logic              w_s2_ready;
    logic [SYN_W-1:0]  w_syn;
    logic              w_corr;
    logic              w_uncorr;
    logic [CODE_W-1:0] w_flip;
    logic              w_xfer;

    assign w_s2_ready = !r_s2_valid || out_ready;
    assign w_s1_ready = !r_s1_valid || w_s2_ready;
    assign w_xfer     = r_s2_valid && out_ready;

    hamming_12_8_syndrome u_syndrome (
        .i_code     (in_code),
        .o_syndrome (w_syn)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_code  <= '0;
            r_s1_syn   <= '0;
        end else if (w_s1_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_code <= in_code;
                r_s1_syn  <= w_syn;
            end
        end
    end

    // Syndromes 13..15 point past the codeword, so nothing is flipped for them.
    assign w_corr   = (r_s1_syn != '0) && (r_s1_syn <= SYN_W'(12));
    assign w_uncorr = (r_s1_syn >= SYN_W'(13));
    assign w_flip   = w_corr ? (CODE_W'(1) << (r_s1_syn - SYN_W'(1))) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid   <= 1'b0;
            r_out_data   <= '0;
            r_out_syn    <= '0;
            r_out_corr   <= 1'b0;
            r_out_uncorr <= 1'b0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data   <= hamming_extract(r_s1_code ^ w_flip);
                r_out_syn    <= r_s1_syn;
                r_out_corr   <= w_corr;
                r_out_uncorr <= w_uncorr;
            end
        end
    end

    // Clear takes priority over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (w_xfer) begin
            if (r_out_corr && (r_corr_cnt != '1)) begin
                r_corr_cnt <= r_corr_cnt + CNT_W'(1);
            end
            if (r_out_uncorr && (r_uncorr_cnt != '1)) begin
                r_uncorr_cnt <= r_uncorr_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready          = w_s1_ready;
    assign out_valid         = r_s2_valid;
    assign out_data          = r_out_data;
    assign out_syndrome      = r_out_syn;
    assign out_corrected     = r_out_corr;
    assign out_uncorrectable = r_out_uncorr;
    assign corr_cnt          = r_corr_cnt;
    assign uncorr_cnt        = r_uncorr_cnt;

endmodule

// File: tb/tb_hamming_12_8_dec.sv
// Self-checking bench for hamming_12_8_dec: directed vectors, backpressure,
// counter saturation, async reset and a randomized stream against a reference model.
module tb_hamming_12_8_dec;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int DIDX [8] = '{2, 4, 5, 6, 8, 9, 10, 11};

    typedef struct {
        logic [7:0] d;
        logic [3:0] s;
        logic       c;
        logic       u;
    } item_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [11:0]      in_code;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic [3:0]       out_syndrome;
    logic             out_corrected;
    logic             out_uncorrectable;
    logic             cnt_clr;
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] uncorr_cnt;

    int         tests = 0;
    int         fails = 0;
    item_t      q[$];
    logic [7:0] emitted[$];
    int         m_corr = 0;
    int         m_uncorr = 0;

    hamming_12_8_dec #(.CNT_W(CNT_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_code           (in_code),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_syndrome      (out_syndrome),
        .out_corrected     (out_corrected),
        .out_uncorrectable (out_uncorrectable),
        .cnt_clr           (cnt_clr),
        .corr_cnt          (corr_cnt),
        .uncorr_cnt        (uncorr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Syndrome as the XOR of the 1-based positions of all set bits.
    function automatic logic [3:0] ref_syn(input logic [11:0] c);
        int s = 0;
        for (int k = 0; k < 12; k++) if (c[k]) s = s ^ (k + 1);
        return 4'(s);
    endfunction

    function automatic logic [11:0] ref_enc(input logic [7:0] d);
        logic [11:0] c = '0;
        logic [3:0]  s;
        for (int i = 0; i < 8; i++) c[DIDX[i]] = d[i];
        s = ref_syn(c);
        c[0] = s[0]; c[1] = s[1]; c[3] = s[2]; c[7] = s[3];
        return c;
    endfunction

    function automatic item_t ref_dec(input logic [11:0] code);
        item_t it;
        logic [11:0] c = code;
        int s;
        s = int'(ref_syn(code));
        it.s = 4'(s);
        it.c = (s >= 1) && (s <= 12);
        it.u = (s >= 13);
        if (it.c) c[s-1] = ~c[s-1];
        for (int i = 0; i < 8; i++) it.d[i] = c[DIDX[i]];
        return it;
    endfunction

    task automatic tick(input logic v, input logic [11:0] code, input logic ordy,
                        input logic clr, output logic acc);
        logic  xf;
        item_t it;
        @(negedge clk);
        in_valid = v; in_code = code; out_ready = ordy; cnt_clr = clr;
        #1;
        chk("in_ready", in_ready, !(q.size() == 2 && !ordy));
        if (q.size() == 0) chk("idle_out_valid", out_valid, 1'b0);
        if (out_valid && q.size() > 0) begin
            chk("out_data", out_data, q[0].d);
            chk("out_syndrome", out_syndrome, q[0].s);
            chk("out_corrected", out_corrected, q[0].c);
            chk("out_uncorrectable", out_uncorrectable, q[0].u);
        end
        acc = v && in_ready;
        xf  = out_valid && ordy;
        if (xf) emitted.push_back(out_data);
        @(posedge clk);
        if (xf && q.size() > 0) begin
            it = q.pop_front();
            if (!clr && it.c && m_corr < CNT_MAX) m_corr++;
            if (!clr && it.u && m_uncorr < CNT_MAX) m_uncorr++;
        end
        if (clr) begin m_corr = 0; m_uncorr = 0; end
        if (acc) q.push_back(ref_dec(code));
        #1;
        chk("corr_cnt", corr_cnt, m_corr);
        chk("uncorr_cnt", uncorr_cnt, m_uncorr);
    endtask

    task automatic drain();
        logic a;
        for (int i = 0; i < 20 && q.size() > 0; i++) tick(1'b0, 12'h000, 1'b1, 1'b0, a);
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        logic        a;
        int          accepts;
        logic [11:0] words [3];
        logic [11:0] cur;
        logic [7:0]  d;

        words[0] = 12'hA27; words[1] = 12'hA37; words[2] = 12'h226;
        rst = 1'b1; in_valid = 1'b0; in_code = '0; out_ready = 1'b0; cnt_clr = 1'b0;
        #3;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_syndrome", out_syndrome, 4'h0);
        chk("rst_flags", {out_corrected, out_uncorrectable}, 2'b00);
        chk("rst_cnts", {corr_cnt, uncorr_cnt}, '0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Clean word: one-cycle gap between accept edge and output register.
        tick(1'b1, 12'hA27, 1'b1, 1'b0, a);
        chk("lat_accept", a, 1'b1);
        chk("lat_edge_n", out_valid, 1'b0);
        tick(1'b0, 12'h000, 1'b1, 1'b0, a);
        chk("lat_edge_n1", out_valid, 1'b1);
        chk("clean_data", out_data, 8'hA5);
        chk("clean_syn", out_syndrome, 4'd0);
        drain();

        tick(1'b1, 12'hA37, 1'b1, 1'b0, a);
        tick(1'b0, 12'h000, 1'b1, 1'b0, a);
        chk("single_data", out_data, 8'hA5);
        chk("single_syn", out_syndrome, 4'd5);
        chk("single_corr", out_corrected, 1'b1);
        drain();
        chk("single_cnt", corr_cnt, 1);

        tick(1'b1, 12'h226, 1'b1, 1'b0, a);
        tick(1'b0, 12'h000, 1'b1, 1'b0, a);
        chk("double_data", out_data, 8'h25);
        chk("double_syn", out_syndrome, 4'd13);
        chk("double_uncorr", out_uncorrectable, 1'b1);
        drain();
        chk("double_cnt", uncorr_cnt, 1);

        // Backpressure: two words fill the pipe, then in_ready must drop.
        emitted.delete();
        accepts = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, words[accepts], 1'b0, 1'b0, a);
            if (a) accepts++;
        end
        chk("bp_accepts", accepts, 2);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_out_valid", out_valid, 1'b1);
        for (int i = 0; i < 10 && accepts < 3; i++) begin
            tick(1'b1, words[accepts], 1'b1, 1'b0, a);
            if (a) accepts++;
        end
        chk("bp_all_accepted", accepts, 3);
        drain();
        chk("bp_count", emitted.size(), 3);
        if (emitted.size() == 3) begin
            chk("bp_order0", emitted[0], 8'hA5);
            chk("bp_order1", emitted[1], 8'hA5);
            chk("bp_order2", emitted[2], 8'h25);
        end

        // Saturation of the narrow counter, then clear racing an increment.
        tick(1'b0, 12'h000, 1'b1, 1'b1, a);
        for (int i = 0; i < 5; i++) tick(1'b1, 12'hA37, 1'b1, 1'b0, a);
        drain();
        chk("sat_corr", corr_cnt, CNT_MAX);
        tick(1'b1, 12'hA37, 1'b1, 1'b0, a);
        tick(1'b0, 12'h000, 1'b1, 1'b0, a);
        chk("clr_race_valid", out_valid, 1'b1);
        tick(1'b0, 12'h000, 1'b1, 1'b1, a);
        chk("clr_race_corr", corr_cnt, 0);

        // Randomized stream; a pending word is held until accepted.
        d = 8'($urandom);
        cur = ref_enc(d);
        for (int n = 0; n < 400; n++) begin
            logic v, o, c;
            v = ($urandom_range(0, 3) != 0);
            o = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 49) == 0);
            tick(v, cur, o, c, a);
            if (a) begin
                d = 8'($urandom);
                cur = ref_enc(d);
                for (int e = $urandom_range(0, 2); e > 0; e--) cur[$urandom_range(0, 11)] ^= 1'b1;
            end
        end

        // Async reset with both stages full.
        tick(1'b1, 12'hA37, 1'b0, 1'b0, a);
        tick(1'b1, 12'h226, 1'b0, 1'b0, a);
        tick(1'b1, 12'hA27, 1'b0, 1'b0, a);
        chk("pre_rst_full", in_ready, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_corr", corr_cnt, 0);
        chk("arst_uncorr", uncorr_cnt, 0);
        q.delete(); m_corr = 0; m_uncorr = 0;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 12'h000, 1'b1, 1'b0, a);
            chk("no_stale", out_valid, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
